// File: rtl/uart_pkg.sv
// Shared constants for the configurable UART blocks: parity encodings,
// transmitter state encodings and baud divisor calculation.
package uart_pkg;

    localparam int PAR_NONE = 0;
    localparam int PAR_ODD  = 1;
    localparam int PAR_EVEN = 2;

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_START  = 3'd1;
    localparam logic [2:0] ST_DATA   = 3'd2;
    localparam logic [2:0] ST_PARITY = 3'd3;
    localparam logic [2:0] ST_STOP   = 3'd4;

    // Clocks per line bit, rounded to nearest.
    function automatic int calc_div(input longint f, input longint baud);
        return int'((f + baud / 2) / baud);
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// Synchronous FIFO with first-word-fall-through read: rd_data always shows
// the head entry while empty is low.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [WIDTH-1:0]             wr_data,
    input  logic                         wr_en,
    output logic                         full,
    output logic [WIDTH-1:0]             rd_data,
    input  logic                         rd_en,
    output logic                         empty,
    output logic [$clog2(DEPTH+1)-1:0]   count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
        $error("sync_fifo: DEPTH must be a power of two and at least 2");
    end

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_wr;
    logic             do_rd;

    assign full    = (count == CW'(DEPTH));
    assign empty   = (count == '0);
    assign do_wr   = wr_en && !full;
    assign do_rd   = rd_en && !empty;
    assign rd_data = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_wr) wr_ptr <= wr_ptr + 1'b1;
            if (do_rd) rd_ptr <= rd_ptr + 1'b1;
            case ({do_wr, do_rd})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_wr) mem[wr_ptr] <= wr_data;
    end

endmodule

// File: rtl/uart_tx_cfg.sv
// Configurable UART transmitter: 5..9 data bits, optional parity, 1 or 2
// stop bits, fed from an input FIFO and sending frames back-to-back.
module uart_tx_cfg
    import uart_pkg::*;
#(
    parameter int F          = 50000000,
    parameter int BAUD       = 115200,
    parameter int DATA_BITS  = 8,
    parameter int PARITY     = 0,
    parameter int STOP_BITS  = 1,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic [DATA_BITS-1:0]              in_data,
    input  logic                              in_valid,
    output logic                              in_ready,
    output logic                              tx,
    output logic                              busy,
    output logic [$clog2(FIFO_DEPTH+1)-1:0]   fifo_count
);

    localparam int DIV   = calc_div(F, BAUD);
    localparam int CNT_W = $clog2(DIV);
    localparam int IDX_W = $clog2(DATA_BITS);

    if (DIV < 2) begin : g_bad_div
        $error("uart_tx_cfg: baud divisor must be at least 2");
    end
    if (DATA_BITS < 5 || DATA_BITS > 9) begin : g_bad_bits
        $error("uart_tx_cfg: DATA_BITS must be 5..9");
    end
    if (PARITY != PAR_NONE && PARITY != PAR_ODD && PARITY != PAR_EVEN) begin : g_bad_par
        $error("uart_tx_cfg: PARITY must be 0, 1 or 2");
    end
    if (STOP_BITS != 1 && STOP_BITS != 2) begin : g_bad_stop
        $error("uart_tx_cfg: STOP_BITS must be 1 or 2");
    end

    logic [2:0]           state;
    logic [CNT_W-1:0]     baud_cnt;
    logic [IDX_W-1:0]     bit_idx;
    logic [DATA_BITS-1:0] shift;
    logic                 par_bit;
    logic [DATA_BITS-1:0] head;
    logic                 fifo_empty;
    logic                 fifo_full;
    logic                 push;
    logic                 pop;
    logic                 bit_tick;
    logic                 last_data;
    logic                 last_stop;
    logic                 tx_next;

    assign in_ready  = !fifo_full;
    assign push      = in_valid && in_ready;
    assign bit_tick  = (baud_cnt == CNT_W'(DIV - 1));
    assign last_data = (bit_idx == IDX_W'(DATA_BITS - 1));
    assign last_stop = (bit_idx == IDX_W'(STOP_BITS - 1));
    // Reloading at the end of the final stop bit keeps frames gap-free.
    assign pop       = !fifo_empty &&
                       ((state == ST_IDLE) || (state == ST_STOP && bit_tick && last_stop));
    assign busy      = (state != ST_IDLE) || (fifo_count != '0);

    sync_fifo #(
        .WIDTH (DATA_BITS),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .wr_data (in_data),
        .wr_en   (push),
        .full    (fifo_full),
        .rd_data (head),
        .rd_en   (pop),
        .empty   (fifo_empty),
        .count   (fifo_count)
    );

    always_comb begin
        tx_next = 1'b1;
        case (state)
            ST_START:  tx_next = 1'b0;
            ST_DATA:   tx_next = shift[0];
            ST_PARITY: tx_next = par_bit;
            default:   tx_next = 1'b1;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= ST_IDLE;
            baud_cnt <= '0;
            bit_idx  <= '0;
            shift    <= '0;
            par_bit  <= 1'b0;
            tx       <= 1'b1;
        end else begin
            tx       <= tx_next;
            // Every transition happens on bit_tick, so this also clears on state entry.
            baud_cnt <= (state == ST_IDLE || bit_tick) ? '0 : baud_cnt + 1'b1;
            if (pop) begin
                shift   <= head;
                par_bit <= (PARITY == PAR_EVEN) ? ^head : ~^head;
            end
            case (state)
                ST_IDLE: begin
                    bit_idx <= '0;
                    if (pop) state <= ST_START;
                end
                ST_START: begin
                    if (bit_tick) begin
                        state   <= ST_DATA;
                        bit_idx <= '0;
                    end
                end
                ST_DATA: begin
                    if (bit_tick) begin
                        shift <= shift >> 1;
                        if (last_data) begin
                            state   <= (PARITY != PAR_NONE) ? ST_PARITY : ST_STOP;
                            bit_idx <= '0;
                        end else begin
                            bit_idx <= bit_idx + 1'b1;
                        end
                    end
                end
                ST_PARITY: begin
                    if (bit_tick) begin
                        state   <= ST_STOP;
                        bit_idx <= '0;
                    end
                end
                ST_STOP: begin
                    if (bit_tick) begin
                        if (last_stop) begin
                            bit_idx <= '0;
                            state   <= pop ? ST_START : ST_IDLE;
                        end else begin
                            bit_idx <= bit_idx + 1'b1;
                        end
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_cfg.sv
// Scoreboard bench for uart_tx_cfg: accepted words are queued as expected
// frames and per-instance line monitors decode tx and compare.
module tb_uart_tx_cfg;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst;
    logic       rst5;
    logic [8:0] din  [6];
    logic       vld  [6];
    logic       rdy  [6];
    logic       txs  [6];
    logic       bsy  [6];
    logic [2:0] fcnt [6];

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int errors = 0;
    int checks = 0;
    int exp_q    [6][$];
    int starts   [6][$];
    int last_par [6];

    // Per instance: data bits, parity mode, stop bits, clocks per bit.
    localparam int NB [6] = '{8, 8, 8, 7, 8, 8};
    localparam int PR [6] = '{0, 2, 1, 0, 0, 0};
    localparam int SB [6] = '{1, 1, 1, 2, 1, 1};
    localparam int DV [6] = '{10, 10, 10, 10, 434, 10};

    uart_tx_cfg #(.F(1000000), .BAUD(100000)) u_a (
        .clk(clk), .rst(rst), .in_data(din[0][7:0]), .in_valid(vld[0]), .in_ready(rdy[0]),
        .tx(txs[0]), .busy(bsy[0]), .fifo_count(fcnt[0]));
    uart_tx_cfg #(.F(1000000), .BAUD(100000), .PARITY(2)) u_b (
        .clk(clk), .rst(rst), .in_data(din[1][7:0]), .in_valid(vld[1]), .in_ready(rdy[1]),
        .tx(txs[1]), .busy(bsy[1]), .fifo_count(fcnt[1]));
    uart_tx_cfg #(.F(1000000), .BAUD(100000), .PARITY(1)) u_c (
        .clk(clk), .rst(rst), .in_data(din[2][7:0]), .in_valid(vld[2]), .in_ready(rdy[2]),
        .tx(txs[2]), .busy(bsy[2]), .fifo_count(fcnt[2]));
    uart_tx_cfg #(.F(1000000), .BAUD(100000), .DATA_BITS(7), .STOP_BITS(2)) u_d (
        .clk(clk), .rst(rst), .in_data(din[3][6:0]), .in_valid(vld[3]), .in_ready(rdy[3]),
        .tx(txs[3]), .busy(bsy[3]), .fifo_count(fcnt[3]));
    uart_tx_cfg u_e (
        .clk(clk), .rst(rst), .in_data(din[4][7:0]), .in_valid(vld[4]), .in_ready(rdy[4]),
        .tx(txs[4]), .busy(bsy[4]), .fifo_count(fcnt[4]));
    uart_tx_cfg #(.F(1000000), .BAUD(100000)) u_f (
        .clk(clk), .rst(rst5), .in_data(din[5][7:0]), .in_valid(vld[5]), .in_ready(rdy[5]),
        .tx(txs[5]), .busy(bsy[5]), .fifo_count(fcnt[5]));

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, got, exp, cyc);
        end
    endtask

    // Decode one frame starting at the current negedge (first low sample).
    task automatic rx_frame(input int k);
        logic [8:0] d;
        int w;
        int p;
        starts[k].push_back(cyc);
        repeat (DV[k] / 2) @(negedge clk);
        check("start_bit", 32'(txs[k]), 0);
        d = '0;
        for (int i = 0; i < NB[k]; i++) begin
            repeat (DV[k]) @(negedge clk);
            d[i] = txs[k];
        end
        check("frame_expected", 32'(exp_q[k].size() != 0), 1);
        w = (exp_q[k].size() != 0) ? exp_q[k].pop_front() : -1;
        check("rx_data", 32'(d), w);
        if (PR[k] != 0) begin
            repeat (DV[k]) @(negedge clk);
            last_par[k] = int'(txs[k]);
            p = $countones(w) % 2;
            if (PR[k] == 1) p = 1 - p;
            check("parity_bit", 32'(txs[k]), p);
        end
        for (int s = 0; s < SB[k]; s++) begin
            repeat (DV[k]) @(negedge clk);
            check("stop_bit", 32'(txs[k]), 1);
        end
    endtask

    for (genvar g = 0; g < 5; g++) begin : g_mon
        initial forever begin
            @(negedge clk);
            if (rst === 1'b0 && txs[g] === 1'b0) rx_frame(g);
        end
    end

    task automatic send(input int k, input logic [8:0] d, output int n);
        logic r;
        n = -1;
        din[k] = d;
        vld[k] = 1'b1;
        for (int i = 0; i < 2000 && n < 0; i++) begin
            r = rdy[k];
            @(posedge clk);
            @(negedge clk);
            if (r) begin
                n = cyc;
                exp_q[k].push_back(int'(d) & ((1 << NB[k]) - 1));
            end
        end
        vld[k] = 1'b0;
        if (n < 0) check("send_accept_timeout", 0, 1);
    endtask

    task automatic wait_idle(input int k, input int n, input int len, input string name);
        int t;
        t = -1;
        for (int i = 0; i < 6000 && t < 0; i++) begin
            if (bsy[k] === 1'b0) t = cyc - n;
            else @(negedge clk);
        end
        check(name, t, len);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int n0;
        int n1;
        int acc;
        int blocked_at;
        int guard;
        int lows;
        int w;
        logic r;

        rst  = 1'b1;
        rst5 = 1'b1;
        for (int k = 0; k < 6; k++) begin
            vld[k]      = 1'b0;
            din[k]      = '0;
            last_par[k] = -1;
        end
        repeat (3) @(negedge clk);
        rst  = 1'b0;
        rst5 = 1'b0;
        for (int k = 0; k < 6; k++) begin
            check("reset_tx", 32'(txs[k]), 1);
            check("reset_in_ready", 32'(rdy[k]), 1);
            check("reset_busy", 32'(bsy[k]), 0);
            check("reset_fifo_count", 32'(fcnt[k]), 0);
        end

        // 8N1, 0x41: latency and frame length
        send(0, 9'h041, n);
        check("count_after_push", 32'(fcnt[0]), 1);
        check("tx_at_n", 32'(txs[0]), 1);
        @(negedge clk);
        check("tx_at_n1", 32'(txs[0]), 1);
        check("count_after_pop", 32'(fcnt[0]), 0);
        @(negedge clk);
        check("tx_fall_at_n2", 32'(txs[0]), 0);
        wait_idle(0, n, 101, "busy_len_8n1");

        // Even then odd parity on 0x41
        send(1, 9'h041, n);
        wait_idle(1, n, 111, "busy_len_8e1");
        check("par_even_0x41", last_par[1], 0);
        send(2, 9'h041, n);
        wait_idle(2, n, 111, "busy_len_8o1");
        check("par_odd_0x41", last_par[2], 1);

        // 7 data bits, 2 stop bits
        send(3, 9'h07F, n);
        wait_idle(3, n, 101, "busy_len_7n2");

        // Burst 0x00..0x09 with in_valid held high
        starts[0].delete();
        acc = 0;
        blocked_at = -1;
        guard = 0;
        n1 = -1;
        vld[0] = 1'b1;
        while (acc < 10 && guard < 3000) begin
            din[0] = 9'(acc);
            r = rdy[0];
            if (!r && blocked_at < 0) begin
                blocked_at = acc;
                check("count_full", 32'(fcnt[0]), 4);
            end
            @(posedge clk);
            @(negedge clk);
            guard++;
            if (r) begin
                if (acc == 0) n1 = cyc;
                exp_q[0].push_back(acc);
                acc++;
            end
        end
        vld[0] = 1'b0;
        check("accepts_before_full", blocked_at, 5);
        check("burst_accepts", acc, 10);
        wait_idle(0, n1, 1001, "busy_len_burst");
        check("burst_frames", starts[0].size(), 10);
        for (int j = 1; j < 10 && j < starts[0].size(); j++)
            check("frame_spacing", starts[0][j] - starts[0][j-1], 100);

        // Reset mid-DATA with three words queued
        send(5, 9'h011, n0);
        send(5, 9'h022, n);
        send(5, 9'h033, n);
        send(5, 9'h044, n);
        check("count_queued", 32'(fcnt[5]), 3);
        while (cyc < n0 + 40) @(negedge clk);
        rst5 = 1'b1;
        @(negedge clk);
        rst5 = 1'b0;
        check("rst_tx", 32'(txs[5]), 1);
        check("rst_fifo_count", 32'(fcnt[5]), 0);
        check("rst_in_ready", 32'(rdy[5]), 1);
        check("rst_busy", 32'(bsy[5]), 0);
        lows = 0;
        repeat (300) begin
            @(negedge clk);
            if (txs[5] !== 1'b1 || bsy[5] !== 1'b0) lows++;
        end
        check("no_frame_after_rst", lows, 0);

        // Default parameters: bit period
        send(4, 9'h001, n);
        for (int i = 0; i < 20 && txs[4] !== 1'b0; i++) @(negedge clk);
        check("default_tx_fall", cyc - n, 2);
        w = 0;
        while (txs[4] === 1'b0 && w < 1000) begin
            @(negedge clk);
            w++;
        end
        check("default_bit_period", w, 434);
        wait_idle(4, n, 4341, "busy_len_default");

        for (int k = 0; k < 5; k++)
            check("queue_drained", exp_q[k].size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
